// File: rtl/timer_pkg.sv
// Shared types and elaboration helpers for the countdown timer.
`timescale 1ns/1ps
package timer_pkg;

  localparam int unsigned COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_t;

  // Clock cycles per decrement.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Prescaler width; DIV >= 2 keeps this at least one bit.
  function automatic int unsigned calc_pre_w(input int unsigned div);
    return (div <= 32'd2) ? 32'd1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-DIV counter; terminal marks the enabled cycle that wraps to zero.
`timescale 1ns/1ps
module tick_prescaler #(
  parameter int unsigned DIV   = 4,
  parameter int unsigned PRE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic sync_clr,
  output logic terminal
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;

  assign terminal = enable && (pre_q == LAST);

  // Frozen whenever enable is low, so a paused partial period survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else if (sync_clr) begin
      pre_q <= '0;
    end else if (enable) begin
      pre_q <= terminal ? '0 : pre_q + PRE_W'(1);
    end
  end

endmodule

// File: rtl/timer_countdown_core.sv
// Seconds countdown engine: button conditioning, run/pause FSM and the 8-bit count.
`timescale 1ns/1ps
module timer_countdown_core
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         start_btn,
  input  logic         pause_btn,
  input  logic         load,
  input  logic         clear,
  input  logic [7:0]   preset,
  output logic [7:0]   count,
  output logic         running,
  output logic         done,
  output logic         tick
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W = calc_pre_w(DIV);

  logic [1:0] start_sync, pause_sync;
  logic       start_prev, pause_prev;
  logic       start_ev, pause_ev;

  timer_state_t        state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                tick_q, tick_d;
  logic                running_q, done_q;
  logic                pre_en_c, pre_clr_c, pre_terminal;

  // Two-flop synchronizers followed by registered rising-edge events.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      start_sync <= '0;
      pause_sync <= '0;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      start_ev   <= 1'b0;
      pause_ev   <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], start_btn};
      pause_sync <= {pause_sync[0], pause_btn};
      start_prev <= start_sync[1];
      pause_prev <= pause_sync[1];
      start_ev   <= start_sync[1] & ~start_prev;
      pause_ev   <= pause_sync[1] & ~pause_prev;
    end
  end

  // A pause on the terminal cycle wins, so the prescaler must not advance then.
  assign pre_en_c = (state_q == RUN) && !clear && !load && !pause_ev;

  tick_prescaler #(
    .DIV   (DIV),
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (Clock),
    .rst_n    (Resetn),
    .enable   (pre_en_c),
    .sync_clr (pre_clr_c),
    .terminal (pre_terminal)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    pre_clr_c = 1'b0;
    if (clear) begin
      count_d   = '0;
      state_d   = IDLE;
      pre_clr_c = 1'b1;
    end else if (load) begin
      count_d   = preset;
      state_d   = IDLE;
      pre_clr_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ev) begin
            if (count_q != '0) begin
              state_d   = RUN;
              pre_clr_c = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
        end
        RUN: begin
          if (pause_ev) begin
            state_d = PAUSED;
          end else if (pre_terminal) begin
            count_d = count_q - COUNT_W'(1);
            tick_d  = 1'b1;
            if (count_q == COUNT_W'(1)) state_d = DONE;
          end
        end
        PAUSED: begin
          if (pause_ev || start_ev) state_d = RUN;
        end
        DONE: begin
          count_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_timer_countdown_core.sv
// Scoreboard bench for timer_countdown_core at DIV=4.
`timescale 1ns/1ps
module tb_timer_countdown_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] preset = 8'd0;
  logic [7:0] count;
  logic       running, done, tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       dn;
    logic       rn;
  } exp_t;

  exp_t exp_q[$];

  timer_countdown_core #(.CLK_HZ(4), .TICK_HZ(1)) dut (
    .Clock     (clk),
    .Resetn    (rst_n),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .load      (load),
    .clear     (clear),
    .preset    (preset),
    .count     (count),
    .running   (running),
    .done      (done),
    .tick      (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  task automatic push(input int c, input int v, input logic dn, input logic rn);
    exp_t e;
    e.cyc = c; e.cnt = 8'(v); e.dn = dn; e.rn = rn;
    exp_q.push_back(e);
  endtask

  // Every tick pulse must match the next expected decrement.
  always @(negedge clk) begin
    if (tick) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_count", int'(count), int'(e.cnt));
        check("tick_done", int'(done), int'(e.dn));
        check("tick_running", int'(running), int'(e.rn));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic load_val(input int v);
    preset = 8'(v);
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("load_count", int'(count), v);
  endtask

  initial begin
    int k, m;

    // Reset then idle
    step(1);
    check("rst_outputs", int'({count, running, done, tick}), 0);
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("idle_outputs", int'({count, running, done, tick}), 0);
    end

    // Full countdown from 3
    load_val(3);
    k = cyc;
    start_btn = 1'b1;
    push(k + 8, 2, 1'b0, 1'b1);
    push(k + 12, 1, 1'b0, 1'b1);
    push(k + 16, 0, 1'b1, 1'b0);
    step(2);
    start_btn = 1'b0;
    wait_until(k + 3);
    check("start_latency_pre", int'(running), 0);
    wait_until(k + 4);
    check("start_latency_run", int'(running), 1);
    check("run_count", int'(count), 3);
    wait_until(k + 20);
    check("countdown_done", int'(done), 1);
    check("countdown_running", int'(running), 0);
    check("countdown_zero", int'(count), 0);

    // Pause after first tick, resume with partial period preserved
    load_val(5);
    check("load_leaves_done", int'(done), 0);
    k = cyc;
    start_btn = 1'b1;
    push(k + 8, 4, 1'b0, 1'b1);
    step(2);
    start_btn = 1'b0;
    wait_until(k + 7);
    pause_btn = 1'b1;
    step(2);
    pause_btn = 1'b0;
    wait_until(k + 11);
    check("paused_running", int'(running), 0);
    check("paused_count", int'(count), 4);
    wait_until(k + 31);
    check("paused_hold_count", int'(count), 4);
    m = cyc;
    pause_btn = 1'b1;
    push(m + 6, 3, 1'b0, 1'b1);
    push(m + 10, 2, 1'b0, 1'b1);
    step(2);
    pause_btn = 1'b0;
    wait_until(m + 3);
    check("resume_pre", int'(running), 0);
    wait_until(m + 4);
    check("resume_run", int'(running), 1);
    wait_until(m + 11);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_count", int'(count), 0);
    check("clear_running", int'(running), 0);

    // Start with zero count goes straight to DONE
    k = cyc;
    start_btn = 1'b1;
    step(2);
    start_btn = 1'b0;
    wait_until(k + 3);
    check("zero_start_pre", int'(done), 0);
    wait_until(k + 4);
    check("zero_start_done", int'(done), 1);
    check("zero_start_running", int'(running), 0);
    k = cyc;
    pause_btn = 1'b1;
    step(2);
    pause_btn = 1'b0;
    wait_until(k + 8);
    check("done_ignores_pause", int'({running, done}), 1);

    // Load wins over the final terminal tick
    load_val(2);
    k = cyc;
    start_btn = 1'b1;
    push(k + 8, 1, 1'b0, 1'b1);
    step(2);
    start_btn = 1'b0;
    wait_until(k + 11);
    preset = 8'd7;
    load = 1'b1;
    step(1);
    load = 1'b0;
    check("load_final_count", int'(count), 7);
    check("load_final_running", int'(running), 0);
    check("load_final_done", int'(done), 0);
    check("load_final_tick", int'(tick), 0);
    step(8);
    check("load_final_idle", int'(count), 7);
    preset = 8'd9;
    load = 1'b1;
    clear = 1'b1;
    step(1);
    load = 1'b0;
    clear = 1'b0;
    check("clear_over_load", int'(count), 0);

    // Asynchronous reset mid-run
    load_val(200);
    k = cyc;
    start_btn = 1'b1;
    push(k + 8, 199, 1'b0, 1'b1);
    step(2);
    start_btn = 1'b0;
    wait_until(k + 9);
    check("prereset_running", int'(running), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_running", int'(running), 0);
    step(1);
    rst_n = 1'b1;
    step(6);
    check("post_rst_outputs", int'({count, running, done, tick}), 0);

    step(4);
    check("missing_ticks", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
